// File: rtl/truth_table_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_checker_pkg
// Description : Shared types and constants for the truth-table checker.
//               Holds the FSM state encoding, the settle counter width
//               and golden truth tables for the two-input guide functions.
//               Table bit i is the expected output for stim == i, where
//               stim = {a, b}.
// Revision    : 1.0 - initial release
// ============================================================================
package truth_table_checker_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Wide enough for the full legal SETTLE range of 1..15.
  localparam int SETTLE_W = 4;

  // Golden tables for the two-input guide functions.
  localparam logic [3:0] TT_AND        = 4'b1000;
  localparam logic [3:0] TT_OR         = 4'b1110;
  localparam logic [3:0] TT_NAND       = 4'b0111;
  localparam logic [3:0] TT_NOR        = 4'b0001;
  localparam logic [3:0] TT_XOR        = 4'b0110;
  localparam logic [3:0] TT_XNOR       = 4'b1001;
  localparam logic [3:0] TT_INHIBIT_AB = 4'b0100;  // a & ~b
  localparam logic [3:0] TT_INHIBIT_BA = 4'b0010;  // ~a & b

endpackage : truth_table_checker_pkg
`default_nettype wire

// File: rtl/truth_table_checker_settle_counter.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_checker_settle_counter
// Description : Loadable down-counter that times the settle interval
//               between driving a vector and sampling the responses.
//               expired_o is high while the count equals 1, so a caller
//               that loads and then decrements every cycle sees expired_o
//               on exactly the SETTLE-th cycle after the load.
// Ports       : clk       - clock, rising edge
//               reset     - asynchronous active-high reset
//               load_i    - load the count with SETTLE (wins over dec_i)
//               dec_i     - decrement the count (saturates at 0)
//               expired_o - count equals 1
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_checker_settle_counter
  import truth_table_checker_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic expired_o
);

  localparam logic [SETTLE_W-1:0] C_SETTLE = SETTLE_W'(SETTLE);
  localparam logic [SETTLE_W-1:0] C_ONE    = SETTLE_W'(1);

  logic [SETTLE_W-1:0] count_q;
  logic [SETTLE_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = C_SETTLE;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - C_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == C_ONE);

endmodule : truth_table_checker_settle_counter
`default_nettype wire

// File: rtl/truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_checker
// Description : Sweeps every N_IN-bit input vector into two candidate
//               implementations, waits SETTLE cycles per vector, then
//               compares both responses against the golden table EXPECT.
//               Reports pass/fail, the number of failing vectors and the
//               first failing vector together with its responses.
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous active-high reset
//               start      - begin a sweep (honoured in IDLE and DONE)
//               resp_a     - response of implementation A (gate-level)
//               resp_b     - response of implementation B (expression)
//               stim       - vector driven to both implementations
//               busy       - sweep in progress
//               done       - sweep complete, results valid
//               pass       - sweep complete with no failing vector
//               err_count  - number of failing vectors this sweep
//               fail_valid - a failing vector has been captured
//               fail_idx   - first failing vector
//               fail_ab    - {resp_a, resp_b} sampled at first failure
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int                   N_IN   = 2,
  parameter int                   SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0] EXPECT = TT_INHIBIT_AB
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            resp_a,
  input  logic            resp_b,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_idx,
  output logic [1:0]      fail_ab
);

  localparam logic [N_IN-1:0] C_LAST     = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] C_STIM_ONE = N_IN'(1);
  localparam logic [N_IN:0]   C_ERR_ONE  = (N_IN + 1)'(1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fail_valid_q, fail_valid_d;
  logic [N_IN-1:0] fail_idx_q, fail_idx_d;
  logic [1:0]      fail_ab_q, fail_ab_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_expired;
  logic exp_bit;
  logic vec_fail;

  truth_table_checker_settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk       (clk),
    .reset     (reset),
    .load_i    (cnt_load),
    .dec_i     (cnt_dec),
    .expired_o (cnt_expired)
  );

  // Either implementation disagreeing marks the vector failed once.
  assign exp_bit  = EXPECT[stim_q];
  assign vec_fail = (resp_a != exp_bit) || (resp_b != exp_bit);

  always_comb begin
    state_d      = state_q;
    stim_d       = stim_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_idx_d   = fail_idx_q;
    fail_ab_d    = fail_ab_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_WAIT;
          stim_d       = '0;
          cnt_load     = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_idx_d   = '0;
          fail_ab_d    = '0;
        end
      end

      S_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_expired) begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (vec_fail) begin
          err_d = err_q + C_ERR_ONE;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_idx_d   = stim_q;
            fail_ab_d    = {resp_a, resp_b};
          end
        end
        if (stim_q == C_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // err_d already includes the vector judged this cycle.
          pass_d  = (err_d == '0);
        end else begin
          state_d  = S_WAIT;
          stim_d   = stim_q + C_STIM_ONE;
          cnt_load = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      stim_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_idx_q   <= '0;
      fail_ab_q    <= '0;
    end else begin
      state_q      <= state_d;
      stim_q       <= stim_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_idx_q   <= fail_idx_d;
      fail_ab_q    <= fail_ab_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_idx   = fail_idx_q;
  assign fail_ab    = fail_ab_q;

endmodule : truth_table_checker
`default_nettype wire

// File: tb/tb_truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_checker
// Description : Self-checking bench for truth_table_checker. Two instances:
//               SETTLE=1 and SETTLE=3. Candidate responses come from two
//               4-bit per-vector tables (ra, rb) indexed by stim, so a test
//               chooses exactly which vectors each implementation gets
//               wrong. Fixed scenarios use hand-computed expectations;
//               random scenarios use a reference model over the tables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_checker;

  localparam logic [3:0] GOLD = 4'b0100;  // a & ~b, stim = {a,b}

  logic clk = 1'b0;
  logic reset;
  logic start0, start1;
  logic [3:0] ra, rb;

  logic [1:0] stim0, stim1;
  logic       resp_a0, resp_b0, resp_a1, resp_b1;
  logic       busy0, done0, pass0, fv0, busy1, done1, pass1, fv1;
  logic [2:0] err0, err1;
  logic [1:0] fidx0, fab0, fidx1, fab1;

  int n_chk  = 0;
  int n_fail = 0;
  int sel_g  = 0;

  always #5 clk = ~clk;

  assign resp_a0 = ra[stim0];
  assign resp_b0 = rb[stim0];
  assign resp_a1 = ra[stim1];
  assign resp_b1 = rb[stim1];

  truth_table_checker #(.N_IN(2), .SETTLE(1), .EXPECT(GOLD)) dut (
    .clk(clk), .reset(reset), .start(start0), .resp_a(resp_a0), .resp_b(resp_b0),
    .stim(stim0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .fail_idx(fidx0), .fail_ab(fab0));

  truth_table_checker #(.N_IN(2), .SETTLE(3), .EXPECT(GOLD)) dut3 (
    .clk(clk), .reset(reset), .start(start1), .resp_a(resp_a1), .resp_b(resp_b1),
    .stim(stim1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_idx(fidx1), .fail_ab(fab1));

  // View of whichever instance the current sweep targets.
  logic [1:0] c_stim, c_fidx, c_fab;
  logic       c_busy, c_done, c_pass, c_fv;
  logic [2:0] c_err;
  always_comb begin
    if (sel_g == 0) begin
      c_stim = stim0; c_busy = busy0; c_done = done0; c_pass = pass0;
      c_err = err0; c_fv = fv0; c_fidx = fidx0; c_fab = fab0;
    end else begin
      c_stim = stim1; c_busy = busy1; c_done = done1; c_pass = pass1;
      c_err = err1; c_fv = fv1; c_fidx = fidx1; c_fab = fab1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0] err;
    bit         fv;
    logic [1:0] fidx;
    logic [1:0] fab;
    bit         pass;
  } result_t;

  // Reference: judge each vector from the golden table independently.
  function automatic result_t model(input logic [3:0] a, input logic [3:0] b);
    result_t r;
    r.err = 0; r.fv = 0; r.fidx = 0; r.fab = 0;
    for (int i = 0; i < 4; i++) begin
      if (a[i] != GOLD[i] || b[i] != GOLD[i]) begin
        r.err = r.err + 3'd1;
        if (!r.fv) begin
          r.fv = 1; r.fidx = 2'(i); r.fab = {a[i], b[i]};
        end
      end
    end
    r.pass = (r.err == 0);
    return r;
  endfunction

  // One full sweep on instance sel; checks start-up clearing, stim walk,
  // latency and the final result.
  task automatic sweep(input int sel, input bit hold, input result_t e, input string tag);
    int s;
    int lat;
    int k;
    int es;
    bit walk_ok;
    s = (sel == 0) ? 1 : 3;
    lat = 4 * (s + 1);
    sel_g = sel;
    @(negedge clk);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
    chk({tag, " start busy"}, int'(c_busy), 1);
    chk({tag, " start done"}, int'(c_done), 0);
    chk({tag, " start clear"}, int'({c_pass, c_fv, c_err, c_fidx, c_fab}), 0);
    k = 0;
    walk_ok = 1;
    while (!c_done && k < lat + 20) begin
      es = k / (s + 1);
      if (es > 3) es = 3;
      if (int'(c_stim) != es || !c_busy) walk_ok = 0;
      @(posedge clk); #1;
      k++;
    end
    start0 = 1'b0; start1 = 1'b0;
    chk({tag, " latency"}, k, lat);
    chk({tag, " stim walk"}, int'(walk_ok), 1);
    chk({tag, " done"}, int'(c_done), 1);
    chk({tag, " busy end"}, int'(c_busy), 0);
    chk({tag, " stim hold"}, int'(c_stim), 3);
    chk({tag, " err_count"}, int'(c_err), int'(e.err));
    chk({tag, " fail_valid"}, int'(c_fv), int'(e.fv));
    chk({tag, " fail_idx"}, int'(c_fidx), int'(e.fidx));
    chk({tag, " fail_ab"}, int'(c_fab), int'(e.fab));
    chk({tag, " pass"}, int'(c_pass), int'(e.pass));
  endtask

  typedef struct {
    logic [3:0] ra;
    logic [3:0] rb;
    result_t    exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    // Hand-computed expectations: {ra, rb, {err, fv, fidx, fab, pass}}
    tbl[0] = '{4'b0100, 4'b0100, '{3'd0, 1'b0, 2'd0, 2'b00, 1'b1}};  // both correct
    tbl[1] = '{4'b0100, 4'b0000, '{3'd1, 1'b1, 2'd2, 2'b10, 1'b0}};  // resp_b tied 0
    tbl[2] = '{4'b1011, 4'b0100, '{3'd4, 1'b1, 2'd0, 2'b10, 1'b0}};  // resp_a inverted
    tbl[3] = '{4'b1111, 4'b1111, '{3'd3, 1'b1, 2'd0, 2'b11, 1'b0}};  // both tied 1
    tbl[4] = '{4'b0100, 4'b0110, '{3'd1, 1'b1, 2'd1, 2'b01, 1'b0}};  // resp_b wrong at 1

    reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    ra = GOLD; rb = GOLD;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", int'({stim0, busy0, done0, pass0, err0, fv0, fidx0, fab0}), 0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven sweeps, back to back: each restart comes from DONE.
    for (int i = 0; i < 5; i++) begin
      ra = tbl[i].ra; rb = tbl[i].rb;
      sweep(0, 1'b0, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Reset during WAIT of vector 1 clears everything before the next edge.
    ra = GOLD; rb = 4'b0000;
    sel_g = 0;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-reset stim", int'(stim0), 1);
    #2 reset = 1'b1;
    #1;
    chk("async reset outputs", int'({stim0, busy0, done0, pass0, err0, fv0, fidx0, fab0}), 0);
    @(negedge clk); reset = 1'b0;
    rb = GOLD;
    sweep(0, 1'b0, model(ra, rb), "after reset");

    // Start held high through the sweep must not restart it.
    sweep(0, 1'b1, model(ra, rb), "start held");

    // Failing sweep then restart from DONE with correct responses.
    ra = 4'b1011; rb = GOLD;
    sweep(0, 1'b0, model(ra, rb), "fail before restart");
    ra = GOLD;
    sweep(0, 1'b0, model(ra, rb), "restart");

    // SETTLE=3 instance: four cycles per vector.
    sweep(1, 1'b0, model(ra, rb), "settle3 ok");
    ra = 4'b0100; rb = 4'b1100;
    sweep(1, 1'b0, model(ra, rb), "settle3 fail");

    // Random response tables against the reference model.
    for (int i = 0; i < 16; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      if ((i % 4) == 0) ra = GOLD;
      sweep(i % 2, 1'b0, model(ra, rb), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_truth_table_checker
`default_nettype wire
